regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the RV32I register file.
- Arbitrates between three writers: the ALU/execute writeback, the LSU load writeback, and a debug write port.
- Tracks outstanding destination registers in a pending-write scoreboard.
- Gives the multicycle control FSM a read-after-write hazard indication for the two source operands.
- Sits between execute/LSU and the register file; drives the regfile's rd_addr, rd_data and write_en.

---
 rtl/regfile_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the RV32I register file with a pending-write scoreboard and hazard detection.
// Define WB_BYPASS_EN to forward the committing ALU/LSU value to decode instead of stalling.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    output logic                      alu_ready,

    input  logic                      lsu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [XLEN-1:0]           lsu_data,
    output logic                      lsu_ready,

    input  logic                      dbg_valid,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_rd,
    input  logic [XLEN-1:0]           dbg_data,
    output logic                      dbg_ready,

    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,

    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      hazard,
    output logic                      fwd1_valid,
    output logic [XLEN-1:0]           fwd1_data,
    output logic                      fwd2_valid,
    output logic [XLEN-1:0]           fwd2_data,

    output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
    output logic [XLEN-1:0]           rf_rd_data,
    output logic                      rf_write_en
);

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    rr_e                       rr_q, rr_d;
    logic [NUM_REGS-1:0]       pending_q, pending_d;
    logic                      wr_en_q, wr_en_d;
    logic                      wr_sb_q, wr_sb_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]           wr_data_q, wr_data_d;

    logic                      alu_gnt, lsu_gnt, dbg_gnt;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [XLEN-1:0]           sel_data;
    logic                      commit_sb;
    logic                      issue_fire;
    logic                      src1_haz, src2_haz;

    // Debug always wins; ALU/LSU share by a round-robin pointer only when both ask.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        rr_d    = rr_q;
        if (dbg_valid) begin
            dbg_gnt = 1'b1;
        end else if (alu_valid && lsu_valid) begin
            if (rr_q == RR_ALU) begin
                alu_gnt = 1'b1;
            end else begin
                lsu_gnt = 1'b1;
            end
        end else if (alu_valid) begin
            alu_gnt = 1'b1;
        end else if (lsu_valid) begin
            lsu_gnt = 1'b1;
        end
        if (alu_gnt) begin
            rr_d = RR_LSU;
        end else if (lsu_gnt) begin
            rr_d = RR_ALU;
        end
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (dbg_gnt) begin
            sel_rd   = dbg_rd;
            sel_data = dbg_data;
        end else if (alu_gnt) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (lsu_gnt) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // x0 writes are accepted but never reach the regfile.
    always_comb begin
        wr_en_d   = (alu_gnt || lsu_gnt || dbg_gnt) && (sel_rd != '0);
        wr_sb_d   = wr_en_d && !dbg_gnt;
        wr_addr_d = wr_en_d ? sel_rd   : wr_addr_q;
        wr_data_d = wr_en_d ? sel_data : wr_data_q;
    end

    assign commit_sb   = wr_en_q && wr_sb_q;
    assign issue_ready = (issue_rd == '0) || !pending_q[issue_rd]
                       || (commit_sb && (wr_addr_q == issue_rd));
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    // Per-register scoreboard bit: a new issue on the commit edge keeps the bit set.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                logic set_bit, clr_bit;
                assign set_bit       = issue_fire && (issue_rd == REG_ADDR_WIDTH'(gi));
                assign clr_bit       = commit_sb && (wr_addr_q == REG_ADDR_WIDTH'(gi));
                assign pending_d[gi] = set_bit || (pending_q[gi] && !clr_bit);
            end
        end
    endgenerate

`ifdef WB_BYPASS_EN
    logic byp1, byp2;
    assign byp1       = commit_sb && (rs1_addr == wr_addr_q);
    assign byp2       = commit_sb && (rs2_addr == wr_addr_q);
    assign fwd1_valid = byp1;
    assign fwd2_valid = byp2;
    assign fwd1_data  = byp1 ? wr_data_q : '0;
    assign fwd2_data  = byp2 ? wr_data_q : '0;
    assign src1_haz   = (rs1_addr != '0) && pending_q[rs1_addr] && !byp1;
    assign src2_haz   = (rs2_addr != '0) && pending_q[rs2_addr] && !byp2;
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
    assign src1_haz   = (rs1_addr != '0) && pending_q[rs1_addr];
    assign src2_haz   = (rs2_addr != '0) && pending_q[rs2_addr];
`endif

    assign hazard = src1_haz || src2_haz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q      <= RR_ALU;
            pending_q <= '0;
            wr_en_q   <= 1'b0;
            wr_sb_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            pending_q <= pending_d;
            wr_en_q   <= wr_en_d;
            wr_sb_q   <= wr_sb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign alu_ready   = alu_gnt;
    assign lsu_ready   = lsu_gnt;
    assign dbg_ready   = dbg_gnt;
    assign rf_write_en = wr_en_q;
    assign rf_rd_addr  = wr_addr_q;
    assign rf_rd_data  = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural scoreboard/arbiter model.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid, dbg_valid, issue_valid;
    logic [4:0]  alu_rd, lsu_rd, dbg_rd, issue_rd, rs1_addr, rs2_addr;
    logic [31:0] alu_data, lsu_data, dbg_data;
    logic        alu_ready, lsu_ready, dbg_ready, issue_ready, hazard;
    logic        fwd1_valid, fwd2_valid, rf_write_en;
    logic [31:0] fwd1_data, fwd2_data, rf_rd_data;
    logic [4:0]  rf_rd_addr;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .dbg_valid   (dbg_valid),
        .dbg_rd      (dbg_rd),
        .dbg_data    (dbg_data),
        .dbg_ready   (dbg_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .hazard      (hazard),
        .fwd1_valid  (fwd1_valid),
        .fwd1_data   (fwd1_data),
        .fwd2_valid  (fwd2_valid),
        .fwd2_data   (fwd2_data),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rf_write_en (rf_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the pending set, which requester the shared turn belongs to,
    // and the write that was accepted at the last edge (visible for one cycle).
    bit          m_pend [32];
    bit          m_turn_lsu;
    bit          m_we, m_sb;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_gnt_alu, m_gnt_lsu, m_gnt_dbg;
    int          win;
    bit          csb, e_ir, e_f1, e_f2, e_h;
    logic [4:0]  w_rd;
    logic [31:0] w_data;

    // Compare at the falling edge, then advance the model past the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            foreach (m_pend[k]) m_pend[k] = 1'b0;
            m_turn_lsu = 1'b0;
            m_we       = 1'b0;
            m_sb       = 1'b0;
        end
        win = -1;
        if (dbg_valid)                   win = 2;
        else if (alu_valid && lsu_valid) win = m_turn_lsu ? 1 : 0;
        else if (alu_valid)              win = 0;
        else if (lsu_valid)              win = 1;
        m_gnt_alu = rst && (win == 0);
        m_gnt_lsu = rst && (win == 1);
        m_gnt_dbg = rst && (win == 2);

        csb  = m_we && m_sb;
        e_ir = (issue_rd == 5'd0) || !m_pend[issue_rd] || (csb && m_addr == issue_rd);
        e_f1 = BYP && csb && (m_addr == rs1_addr);
        e_f2 = BYP && csb && (m_addr == rs2_addr);
        e_h  = ((rs1_addr != 5'd0) && m_pend[rs1_addr] && !e_f1) ||
               ((rs2_addr != 5'd0) && m_pend[rs2_addr] && !e_f2);

        chk_b("alu_ready", alu_ready, win == 0);
        chk_b("lsu_ready", lsu_ready, win == 1);
        chk_b("dbg_ready", dbg_ready, win == 2);
        chk_b("issue_ready", issue_ready, e_ir);
        chk_b("hazard", hazard, e_h);
        chk_b("fwd1_valid", fwd1_valid, e_f1);
        chk_b("fwd2_valid", fwd2_valid, e_f2);
        if (e_f1 || !BYP) chk_w("fwd1_data", fwd1_data, e_f1 ? m_data : 32'd0);
        if (e_f2 || !BYP) chk_w("fwd2_data", fwd2_data, e_f2 ? m_data : 32'd0);
        chk_b("rf_write_en", rf_write_en, m_we);
        if (m_we) begin
            chk_w("rf_rd_addr", 32'(rf_rd_addr), 32'(m_addr));
            chk_w("rf_rd_data", rf_rd_data, m_data);
        end

        if (rst) begin
            if (csb) m_pend[m_addr] = 1'b0;
            if (issue_valid && e_ir && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
            w_rd   = (win == 2) ? dbg_rd   : (win == 1) ? lsu_rd   : alu_rd;
            w_data = (win == 2) ? dbg_data : (win == 1) ? lsu_data : alu_data;
            m_we = (win >= 0) && (w_rd != 5'd0);
            m_sb = (win != 2);
            if (m_we) begin
                m_addr = w_rd;
                m_data = w_data;
            end
            if (win == 0) m_turn_lsu = 1'b1;
            if (win == 1) m_turn_lsu = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] gd;

    initial begin
        rst = 1'b1;
        {alu_valid, lsu_valid, dbg_valid, issue_valid} = '0;
        {alu_rd, lsu_rd, dbg_rd, issue_rd, rs1_addr, rs2_addr} = '0;
        {alu_data, lsu_data, dbg_data} = '0;
        #2 rst = 1'b0;

        // Reset state
        at_neg();
        chk_b("reset_we", rf_write_en, 1'b0);
        chk_w("reset_addr", 32'(rf_rd_addr), 32'd0);
        chk_w("reset_data", rf_rd_data, 32'd0);
        tick();
        rst = 1'b1;
        rs1_addr = 5'd2;
        rs2_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk_b("post_reset_we", rf_write_en, 1'b0);
            chk_b("post_reset_hazard", hazard, 1'b0);
            tick();
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd2;
        at_neg();
        chk_b("issue_x2_ready", issue_ready, 1'b1);
        tick();
        issue_valid = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;

        // ALU/LSU contention alternates
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h100;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h200;
        gd = '0;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk_b("rr_alu_ready", alu_ready, (i % 2) == 0);
            chk_b("rr_lsu_ready", lsu_ready, (i % 2) == 1);
            if (i > 0) begin
                chk_b("rr_we", rf_write_en, 1'b1);
                chk_w("rr_addr", 32'(rf_rd_addr), (i % 2 == 1) ? 32'd5 : 32'd6);
                chk_w("rr_data", rf_rd_data, gd);
            end
            gd = (i % 2 == 0) ? alu_data : lsu_data;
            tick();
            if (i % 2 == 0) alu_data = 32'h100 + 32'(i) + 32'd1;
            else            lsu_data = 32'h200 + 32'(i) + 32'd1;
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        tick();

        // Debug beats ALU and leaves the scoreboard alone
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_data = 32'hDEAD;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h8888;
        rs1_addr  = 5'd7;
        at_neg();
        chk_b("dbg_ready", dbg_ready, 1'b1);
        chk_b("dbg_alu_blocked", alu_ready, 1'b0);
        tick();
        dbg_valid = 1'b0;
        at_neg();
        chk_b("dbg_then_alu", alu_ready, 1'b1);
        chk_w("dbg_commit_addr", 32'(rf_rd_addr), 32'd7);
        chk_w("dbg_commit_data", rf_rd_data, 32'hDEAD);
        chk_b("dbg_commit_hazard", hazard, 1'b1);
        tick();
        alu_valid = 1'b0;
        at_neg();
        chk_w("alu8_commit_addr", 32'(rf_rd_addr), 32'd8);
        chk_b("x7_still_pending", hazard, 1'b1);
        tick();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        repeat (2) tick();

        // RAW hazard on x10
        issue_valid = 1'b1; issue_rd = 5'd10;
        rs1_addr = 5'd10; rs2_addr = 5'd0;
        tick();
        issue_valid = 1'b0;
        repeat (2) begin
            at_neg();
            chk_b("x10_hazard", hazard, 1'b1);
            tick();
        end
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1234;
        at_neg();
        chk_b("x10_alu_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        at_neg();
`ifdef WB_BYPASS_EN
        chk_b("x10_commit_hazard", hazard, 1'b0);
        chk_b("x10_fwd_valid", fwd1_valid, 1'b1);
        chk_w("x10_fwd_data", fwd1_data, 32'h1234);
`else
        chk_b("x10_commit_hazard", hazard, 1'b1);
        chk_b("x10_fwd_valid", fwd1_valid, 1'b0);
`endif
        tick();
        at_neg();
        chk_b("x10_after_hazard", hazard, 1'b0);
        tick();
        rs1_addr = 5'd0;

        // WAW stall on x12
        issue_valid = 1'b1; issue_rd = 5'd12;
        at_neg();
        chk_b("x12_first_issue", issue_ready, 1'b1);
        tick();
        at_neg();
        chk_b("x12_waw_stall", issue_ready, 1'b0);
        tick();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h5555;
        at_neg();
        chk_b("x12_waw_stall2", issue_ready, 1'b0);
        tick();
        alu_valid = 1'b0;
        at_neg();
        chk_b("x12_commit_issue", issue_ready, 1'b1);
        tick();
        issue_valid = 1'b0;
        rs1_addr = 5'd12;
        at_neg();
        chk_b("x12_still_pending", hazard, 1'b1);
        tick();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12;
        tick();
        alu_valid = 1'b0;
        rs1_addr = 5'd0;
        tick();

        // x0 write, then reset with a write in flight
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        at_neg();
        chk_b("x0_alu_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        at_neg();
        chk_b("x0_no_we", rf_write_en, 1'b0);
        tick();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        at_neg();
        chk_b("x9_alu_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        rst = 1'b0;
        rs1_addr = 5'd9;
        at_neg();
        chk_b("rst_mid_we", rf_write_en, 1'b0);
        chk_w("rst_mid_addr", 32'(rf_rd_addr), 32'd0);
        chk_b("rst_mid_hazard", hazard, 1'b0);
        tick();
        rst = 1'b1;
        at_neg();
        chk_b("rst_rel_we", rf_write_en, 1'b0);
        chk_b("rst_rel_hazard", hazard, 1'b0);
        tick();

        // Randomized traffic; requesters hold until accepted
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b0;
                alu_valid = 1'b0;
                lsu_valid = 1'b0;
                dbg_valid = 1'b0;
                issue_valid = 1'b0;
            end else begin
                rst = 1'b1;
                if (!alu_valid || m_gnt_alu) begin
                    alu_valid = 1'($urandom_range(0, 1));
                    alu_rd    = 5'($urandom_range(0, 7));
                    alu_data  = $urandom;
                end
                if (!lsu_valid || m_gnt_lsu) begin
                    lsu_valid = 1'($urandom_range(0, 1));
                    lsu_rd    = 5'($urandom_range(0, 7));
                    lsu_data  = $urandom;
                end
                if (!dbg_valid || m_gnt_dbg) begin
                    dbg_valid = ($urandom_range(0, 7) == 0);
                    dbg_rd    = 5'($urandom_range(0, 7));
                    dbg_data  = $urandom;
                end
                issue_valid = 1'($urandom_range(0, 1));
                issue_rd    = 5'($urandom_range(0, 7));
            end
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            tick();
        end

        rst = 1'b1;
        {alu_valid, lsu_valid, dbg_valid, issue_valid} = '0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
